// File: rtl/inst_issue_splitter.sv
// inst_issue_splitter
// Splits one buffered 4-slot fetch group into left-packed issue bundles of
// up to ISSUE_WIDTH (1 or 2) instructions, in ascending slot order, dropping
// invalid slots. The buffer head is popped (out_ready) only in the cycle its
// last valid instruction is accepted; an all-zero mask is popped at once.
//
// Optional feature macro: INST_ISSUE_OUT_REG_EN
//   defined   : one-entry output register (1 cycle latency, full throughput)
//   undefined : purely combinational bundle path (zero latency)
//
// Handshake: a bundle transfers in a cycle where out_valid && next_ready;
// the head group transfers from the buffer in a cycle where pre_valid &&
// out_ready. While valid is high without ready, the offered data holds.
module inst_issue_splitter #(
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [127:0]             inst_4W,
  input  logic [3:0]               inst_4W_valid,
  input  logic                     pre_valid,
  output logic                     out_ready,
  output logic [32*ISSUE_WIDTH-1:0] inst_issue,
  output logic [ISSUE_WIDTH-1:0]   inst_issue_valid,
  output logic                     out_valid,
  input  logic                     next_ready
);

  // OR of the slots named by a one-hot (or empty) select; empty gives 0.
  function automatic logic [31:0] pick_slot(input logic [127:0] grp,
                                            input logic [3:0]   onehot);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (onehot[k]) r = r | grp[32*k +: 32];
    end
    return r;
  endfunction

  logic [3:0]               taken;
  logic [3:0]               rem;
  logic [3:0]               sel0;
  logic [3:0]               sel1;
  logic [3:0]               issue;
  logic                     bundle_valid;
  logic                     accept;
  logic                     fire;
  logic                     last;
  logic [32*ISSUE_WIDTH-1:0] bundle_data;
  logic [ISSUE_WIDTH-1:0]   bundle_lane_valid;

  // Slots of the head group still waiting to be issued.
  assign rem  = pre_valid ? (inst_4W_valid & ~taken) : 4'b0000;
  // Lowest set bit: oldest remaining slot goes to lane 0.
  assign sel0 = rem & (~rem + 4'd1);

  generate
    if (ISSUE_WIDTH == 2) begin : g_dual
      logic [3:0] rem1;
      assign rem1              = rem & ~sel0;
      assign sel1              = rem1 & (~rem1 + 4'd1);
      assign bundle_data       = {pick_slot(inst_4W, sel1), pick_slot(inst_4W, sel0)};
      assign bundle_lane_valid = {|sel1, |sel0};
    end else begin : g_single
      assign sel1              = 4'b0000;
      assign bundle_data       = pick_slot(inst_4W, sel0);
      assign bundle_lane_valid = |sel0;
    end
  endgenerate

  assign issue        = sel0 | sel1;
  assign bundle_valid = (rem != 4'b0000);
  assign fire         = bundle_valid && accept;
  assign last         = ((rem & ~issue) == 4'b0000);
  assign out_ready    = !rst && pre_valid && (!bundle_valid || (fire && last));

  // Issued-slot tracking; cleared on pop, on empty head, and on reset.
  always_ff @(posedge clk) begin
    if (rst || out_ready || !pre_valid) begin
      taken <= 4'b0000;
    end else if (fire) begin
      taken <= taken | issue;
    end
  end

`ifdef INST_ISSUE_OUT_REG_EN
  logic [32*ISSUE_WIDTH-1:0] q_data;
  logic [ISSUE_WIDTH-1:0]   q_lane_valid;
  logic                     q_valid;

  assign accept = !q_valid || next_ready;

  // Output register: loads the selected bundle (zeros when nothing fires).
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid      <= 1'b0;
      q_data       <= '0;
      q_lane_valid <= '0;
    end else if (accept) begin
      q_valid      <= fire;
      q_data       <= bundle_data;
      q_lane_valid <= bundle_lane_valid;
    end
  end

  assign out_valid        = !rst && q_valid;
  assign inst_issue       = rst ? '0 : q_data;
  assign inst_issue_valid = rst ? '0 : q_lane_valid;
`else
  assign accept           = next_ready;
  assign out_valid        = !rst && bundle_valid;
  assign inst_issue       = rst ? '0 : bundle_data;
  assign inst_issue_valid = rst ? '0 : bundle_lane_valid;
`endif

endmodule

// File: tb/tb_inst_issue_splitter.sv
// Testbench for inst_issue_splitter (ISSUE_WIDTH = 2). A small buffer model
// feeds groups; every valid slot is pushed to exp_q when the group is queued
// and popped when the DUT hands the matching lane to the decoder.
module tb_inst_issue_splitter;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  inst_4W;
  logic [3:0]    inst_4W_valid;
  logic          pre_valid;
  logic          out_ready;
  logic [32*IW-1:0] inst_issue;
  logic [IW-1:0] inst_issue_valid;
  logic          out_valid;
  logic          next_ready;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   mask;
  } grp_t;

  grp_t        grp_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          gid      = 0;

  logic          s_out_valid;
  logic          s_out_ready;
  logic [32*IW-1:0] s_issue;
  logic [IW-1:0] s_issue_valid;

  inst_issue_splitter #(.ISSUE_WIDTH(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_4W          (inst_4W),
    .inst_4W_valid    (inst_4W_valid),
    .pre_valid        (pre_valid),
    .out_ready        (out_ready),
    .inst_issue       (inst_issue),
    .inst_issue_valid (inst_issue_valid),
    .out_valid        (out_valid),
    .next_ready       (next_ready)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] inst_of(input int g, input int k);
    return 32'hA000_0000 | (32'(g) << 4) | 32'(k);
  endfunction

  // Queue a group in the buffer model and its valid slots in the scoreboard.
  task automatic push_group(input logic [3:0] mask);
    grp_t g;
    g.data = '0;
    g.mask = mask;
    for (int k = 0; k < 4; k++) begin
      g.data[32*k +: 32] = inst_of(gid, k);
      if (mask[k]) exp_q.push_back(inst_of(gid, k));
    end
    grp_q.push_back(g);
    gid++;
  endtask

  // Compare an accepted bundle against the scoreboard.
  task automatic score();
    check("valid_has_lane", {127'd0, |s_issue_valid}, 128'd1);
    for (int j = 0; j < IW; j++) begin
      if (s_issue_valid[j]) begin
        if (exp_q.size() == 0) check("spurious_lane", {127'd0, s_issue_valid[j]}, 128'd0);
        else check("lane_data", {96'd0, s_issue[32*j +: 32]}, {96'd0, exp_q.pop_front()});
      end else begin
        check("idle_lane_zero", {96'd0, s_issue[32*j +: 32]}, 128'd0);
      end
    end
    if (s_issue_valid[1]) check("left_packed", {127'd0, s_issue_valid[0]}, 128'd1);
  endtask

  // One cycle: drive at negedge, sample #1 later, pop the buffer at posedge.
  task automatic step(input logic nr, input logic r);
    @(negedge clk);
    rst        = r;
    next_ready = nr;
    if (grp_q.size() > 0) begin
      pre_valid     = 1'b1;
      inst_4W       = grp_q[0].data;
      inst_4W_valid = grp_q[0].mask;
    end else begin
      pre_valid     = 1'b0;
      inst_4W       = '0;
      inst_4W_valid = '0;
    end
    #1;
    s_out_valid   = out_valid;
    s_out_ready   = out_ready;
    s_issue       = inst_issue;
    s_issue_valid = inst_issue_valid;
    if (s_out_ready && !pre_valid) check("pop_without_group", {127'd0, s_out_ready}, 128'd0);
    if (!r && s_out_valid && nr) score();
    @(posedge clk);
    if (s_out_ready && grp_q.size() > 0) grp_q.delete(0);
  endtask

  initial begin
    int g;
    int guard;
    rst = 1'b1; next_ready = 1'b0; pre_valid = 1'b0;
    inst_4W = '0; inst_4W_valid = '0;

    // Reset with a group present: everything forced low.
    push_group(4'b1111);
    step(1'b1, 1'b1);
    check("rst_out_valid", {127'd0, s_out_valid}, 128'd0);
    check("rst_out_ready", {127'd0, s_out_ready}, 128'd0);
    check("rst_issue_valid", {126'd0, s_issue_valid}, 128'd0);
    check("rst_issue", {64'd0, s_issue}, 128'd0);
    grp_q.delete(); exp_q.delete();

`ifdef INST_ISSUE_OUT_REG_EN
    // Registered mode: first bundle one cycle after the head appears.
    g = gid; push_group(4'b1111);
    step(1'b1, 1'b0);
    check("reg_lat_first_invalid", {127'd0, s_out_valid}, 128'd0);
    step(1'b1, 1'b0);
    check("reg_lat_bundle0_valid", {127'd0, s_out_valid}, 128'd1);
    check("reg_lat_bundle0", {64'd0, s_issue}, {64'd0, inst_of(g, 1), inst_of(g, 0)});
    step(1'b1, 1'b0);
    check("reg_lat_bundle1", {64'd0, s_issue}, {64'd0, inst_of(g, 3), inst_of(g, 2)});
`else
    // Full group: two bundles, pop in the second cycle.
    g = gid; push_group(4'b1111);
    step(1'b1, 1'b0);
    check("full_c0_valid", {126'd0, s_issue_valid}, 128'd3);
    check("full_c0_ready", {127'd0, s_out_ready}, 128'd0);
    check("full_c0_data", {64'd0, s_issue}, {64'd0, inst_of(g, 1), inst_of(g, 0)});
    step(1'b1, 1'b0);
    check("full_c1_valid", {126'd0, s_issue_valid}, 128'd3);
    check("full_c1_ready", {127'd0, s_out_ready}, 128'd1);
    check("full_c1_data", {64'd0, s_issue}, {64'd0, inst_of(g, 3), inst_of(g, 2)});

    // Sparse masks.
    g = gid; push_group(4'b1010);
    step(1'b1, 1'b0);
    check("m1010_valid", {126'd0, s_issue_valid}, 128'd3);
    check("m1010_ready", {127'd0, s_out_ready}, 128'd1);
    check("m1010_data", {64'd0, s_issue}, {64'd0, inst_of(g, 3), inst_of(g, 1)});
    g = gid; push_group(4'b0100);
    step(1'b1, 1'b0);
    check("m0100_valid", {126'd0, s_issue_valid}, 128'd1);
    check("m0100_data", {64'd0, s_issue}, {96'd0, inst_of(g, 2)});
    check("m0100_ready", {127'd0, s_out_ready}, 128'd1);

    // Empty mask: popped in one cycle, no bundle.
    push_group(4'b0000);
    step(1'b1, 1'b0);
    check("m0000_out_valid", {127'd0, s_out_valid}, 128'd0);
    check("m0000_ready", {127'd0, s_out_ready}, 128'd1);
    step(1'b1, 1'b0);
    check("m0000_ready_once", {127'd0, s_out_ready}, 128'd0);

    // Stall after the first bundle fires.
    g = gid; push_group(4'b1111);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("stall_valid", {126'd0, s_issue_valid}, 128'd3);
      check("stall_data", {64'd0, s_issue}, {64'd0, inst_of(g, 3), inst_of(g, 2)});
      check("stall_ready", {127'd0, s_out_ready}, 128'd0);
    end
    step(1'b1, 1'b0);
    check("stall_release_ready", {127'd0, s_out_ready}, 128'd1);

    // Reset mid-group, then a fresh group starts from slot 0.
    push_group(4'b1111);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midrst_out_valid", {127'd0, s_out_valid}, 128'd0);
    check("midrst_out_ready", {127'd0, s_out_ready}, 128'd0);
    check("midrst_issue_valid", {126'd0, s_issue_valid}, 128'd0);
    check("midrst_issue", {64'd0, s_issue}, 128'd0);
    grp_q.delete(); exp_q.delete();
    g = gid; push_group(4'b1111);
    step(1'b1, 1'b0);
    check("postrst_data", {64'd0, s_issue}, {64'd0, inst_of(g, 1), inst_of(g, 0)});
    check("postrst_ready", {127'd0, s_out_ready}, 128'd0);
`endif

    // Random masks and decoder stalls.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (grp_q.size() < 3 && $urandom_range(0, 2) != 0) push_group(4'($urandom_range(0, 15)));
      step($urandom_range(0, 3) != 0, 1'b0);
    end

    // Drain everything still queued.
    guard = 0;
    while ((grp_q.size() > 0 || exp_q.size() > 0) && guard < 100) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("drain_exp_empty", 128'(exp_q.size()), 128'd0);
    check("drain_buf_empty", 128'(grp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
